// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer states and
// default limits used by the arbiter and its bench.
package dmem_arb_pkg;

    // Dump sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Default number of consecutive denied dump cycles before a forced slot
    localparam int STARVE_MAX_DEF = 8;

    // Width of the starvation counter (covers STARVE_MAX up to 255)
    localparam int STARVE_W = 8;

    // Width of the dump word index / memory word address
    localparam int WORD_W = 6;

endpackage

// File: rtl/flopr.sv
// Generic register with synchronous active-high clear.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d every cycle; reset clears the register to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single data memory between the CPU MEM stage and an internal
// sequencer that dumps words 0..DEPTH-1. The CPU normally wins; after
// STARVE_MAX consecutive denied dump cycles the dump takes one slot and the
// CPU is stalled for that cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N          = 64,
    parameter int DEPTH      = 64,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // CPU side
    input  logic              cpu_memRead,
    input  logic              cpu_memWrite,
    input  logic [N-1:0]      cpu_addr,
    input  logic [N-1:0]      cpu_writeData,
    output logic [N-1:0]      cpu_readData,
    output logic              cpu_stall,
    // Dump side
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [WORD_W-1:0] dump_addr,
    output logic [N-1:0]      dump_data,
    output logic              dump_done,
    // Memory side
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic [WORD_W-1:0] mem_address,
    output logic [N-1:0]      mem_writeData,
    input  logic [N-1:0]      mem_readData
);

    localparam logic [WORD_W-1:0]   LAST_WORD  = WORD_W'(DEPTH - 1);
    localparam logic [WORD_W-1:0]   WORD_ONE   = WORD_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
    localparam int                  STAGE_W    = 1 + WORD_W + N;

    arb_state_e          state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic cpu_req_s;
    logic in_dump_s;
    logic forced_s;
    logic dump_grant_s;

    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] stage_q;

    // Grant decision: CPU first, dump when CPU idle or when starvation forces a slot
    always_comb begin
        cpu_req_s    = cpu_memRead | cpu_memWrite;
        in_dump_s    = (state_q == DUMP) && !reset;
        forced_s     = in_dump_s && cpu_req_s && (starve_q >= STARVE_LIM);
        dump_grant_s = in_dump_s && (!cpu_req_s || forced_s);
    end

    // State, word counter and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            starve_q <= starve_d;
        end
    end

    // Sequencer next-state: walk words on each dump grant, track denied cycles
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                word_d   = '0;
                starve_d = '0;
                if (dump_start) begin
                    state_d = DUMP;
                end else begin
                    state_d = IDLE;
                end
            end
            DUMP: begin
                if (dump_grant_s) begin
                    starve_d = '0;
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + WORD_ONE;
                        state_d = DUMP;
                    end
                end else begin
                    starve_d = starve_q + STARVE_ONE;
                    state_d  = DUMP;
                end
            end
            DONE: begin
                word_d   = '0;
                starve_d = '0;
                state_d  = IDLE;
            end
            default: begin
                word_d   = '0;
                starve_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // Memory port mux: dump read on grant, otherwise CPU pass-through (zero when idle)
    always_comb begin
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        if (dump_grant_s) begin
            mem_memRead   = 1'b1;
            mem_memWrite  = 1'b0;
            mem_address   = word_q;
            mem_writeData = '0;
        end else if (cpu_req_s) begin
            mem_memRead   = cpu_memRead;
            mem_memWrite  = cpu_memWrite;
            mem_address   = cpu_addr[8:3];
            mem_writeData = cpu_writeData;
        end else begin
            mem_memRead   = 1'b0;
            mem_memWrite  = 1'b0;
            mem_address   = '0;
            mem_writeData = '0;
        end
    end

    // Dump output stage input: capture word and index on grant, else hold with valid low
    always_comb begin
        stage_d = '0;
        if (dump_grant_s) begin
            stage_d = {1'b1, word_q, mem_readData};
        end else begin
            stage_d = {1'b0, dump_addr, dump_data};
        end
    end

    flopr #(
        .WIDTH (STAGE_W)
    ) u_dump_stage (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d),
        .q     (stage_q)
    );

    assign dump_valid   = stage_q[STAGE_W-1];
    assign dump_addr    = stage_q[N +: WORD_W];
    assign dump_data    = stage_q[N-1:0];

    assign cpu_readData = mem_readData;
    assign cpu_stall    = forced_s;
    assign dump_busy    = (state_q != IDLE);
    assign dump_done    = (state_q == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of CPU pass-through vectors,
// directed dump sequences, and randomized traffic compared against a
// cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int N     = 64;
    localparam int DEPTH = 64;
    localparam int SMAX  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_memRead, cpu_memWrite;
    logic [N-1:0] cpu_addr, cpu_writeData, cpu_readData;
    logic         cpu_stall;
    logic         dump_start, dump_busy, dump_valid, dump_done;
    logic [5:0]   dump_addr;
    logic [N-1:0] dump_data;
    logic         mem_memRead, mem_memWrite;
    logic [5:0]   mem_address;
    logic [N-1:0] mem_writeData, mem_readData;

    logic [N-1:0] mem_arr [DEPTH];

    int checks   = 0;
    int failures = 0;

    // Reference model state (phase: 0 idle, 1 dumping, 2 done)
    int           m_phase = 0, m_word = 0, m_denied = 0;
    logic         m_valid = 1'b0;
    logic [5:0]   m_addr  = 6'd0;
    logic [N-1:0] m_data  = 64'd0;
    int           n_phase, n_word, n_denied;
    logic         n_valid;
    logic [5:0]   n_addr;
    logic [N-1:0] n_data;

    // Event counters for directed sequences
    int cnt_valid, cnt_done, cnt_stall, cnt_dumpcyc;
    int order_idx = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [N-1:0] addr;
        logic [N-1:0] wd;
        logic         e_rd;
        logic         e_wr;
        logic [5:0]   e_a;
        logic [N-1:0] e_wd;
    } vec_t;

    vec_t vt [6];

    dmem_arbiter #(.N(N), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_memRead   (cpu_memRead),
        .cpu_memWrite  (cpu_memWrite),
        .cpu_addr      (cpu_addr),
        .cpu_writeData (cpu_writeData),
        .cpu_readData  (cpu_readData),
        .cpu_stall     (cpu_stall),
        .dump_start    (dump_start),
        .dump_busy     (dump_busy),
        .dump_valid    (dump_valid),
        .dump_addr     (dump_addr),
        .dump_data     (dump_data),
        .dump_done     (dump_done),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on clock edge
    assign mem_readData = mem_arr[mem_address];
    always @(posedge clk) begin
        if (mem_memWrite) mem_arr[mem_address] <= mem_writeData;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare same-cycle outputs with the model and precompute the model's next state
    task automatic model_comb();
        logic req, dumping, forced, grant, e_rd, e_wr;
        logic [5:0]   e_a;
        logic [N-1:0] e_wd;
        req     = cpu_memRead | cpu_memWrite;
        dumping = (m_phase == 1) && !reset;
        forced  = dumping && req && (m_denied >= SMAX);
        grant   = dumping && (!req || forced);
        if (grant) begin
            e_rd = 1'b1; e_wr = 1'b0; e_a = 6'(m_word); e_wd = 64'd0;
        end else if (req) begin
            e_rd = cpu_memRead; e_wr = cpu_memWrite; e_a = cpu_addr[8:3]; e_wd = cpu_writeData;
        end else begin
            e_rd = 1'b0; e_wr = 1'b0; e_a = 6'd0; e_wd = 64'd0;
        end
        chk("mem_memRead",   64'(mem_memRead),  64'(e_rd));
        chk("mem_memWrite",  64'(mem_memWrite), 64'(e_wr));
        chk("mem_address",   64'(mem_address),  64'(e_a));
        chk("mem_writeData", mem_writeData,     e_wd);
        chk("cpu_stall",     64'(cpu_stall),    64'(forced));
        chk("cpu_readData",  cpu_readData,      mem_arr[e_a]);
        if (cpu_stall) cnt_stall++;

        n_phase = m_phase; n_word = m_word; n_denied = m_denied;
        n_valid = m_valid; n_addr = m_addr; n_data = m_data;
        if (reset) begin
            n_phase = 0; n_word = 0; n_denied = 0;
            n_valid = 1'b0; n_addr = 6'd0; n_data = 64'd0;
        end else begin
            n_valid = grant;
            if (grant) begin
                n_addr = 6'(m_word);
                n_data = mem_arr[6'(m_word)];
            end
            if (m_phase == 0) begin
                if (dump_start) begin n_phase = 1; n_word = 0; n_denied = 0; end
            end else if (m_phase == 1) begin
                if (grant) begin
                    n_denied = 0;
                    if (m_word == DEPTH - 1) begin n_phase = 2; n_word = 0; end
                    else n_word = m_word + 1;
                end else begin
                    n_denied = m_denied + 1;
                end
            end else begin
                n_phase = 0;
            end
        end
    endtask

    task automatic apply(input logic rst, input logic st, input logic rd, input logic wr,
                         input logic [N-1:0] a, input logic [N-1:0] wd);
        reset = rst; dump_start = st; cpu_memRead = rd; cpu_memWrite = wr;
        cpu_addr = a; cpu_writeData = wd;
        #1;
        model_comb();
    endtask

    // Advance one clock and compare registered outputs against the model
    task automatic edge_chk();
        @(posedge clk);
        #1;
        m_phase = n_phase; m_word = n_word; m_denied = n_denied;
        m_valid = n_valid; m_addr = n_addr; m_data = n_data;
        chk("dump_valid", 64'(dump_valid), 64'(m_valid));
        chk("dump_addr",  64'(dump_addr),  64'(m_addr));
        chk("dump_data",  dump_data,       m_data);
        chk("dump_busy",  64'(dump_busy),  64'(m_phase != 0));
        chk("dump_done",  64'(dump_done),  64'(m_phase == 2));
        if (reset) begin
            order_idx = 0;
        end else if (dump_valid) begin
            chk("dump_order", 64'(dump_addr), 64'(order_idx));
            order_idx = (order_idx + 1) % DEPTH;
        end
        if (dump_valid) cnt_valid++;
        if (dump_done) cnt_done++;
        if (dump_busy && !dump_done) cnt_dumpcyc++;
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rd, input logic wr,
                       input logic [N-1:0] a, input logic [N-1:0] wd);
        apply(rst, st, rd, wr, a, wd);
        edge_chk();
    endtask

    task automatic clr_counts();
        cnt_valid = 0; cnt_done = 0; cnt_stall = 0; cnt_dumpcyc = 0;
    endtask

    function automatic logic [N-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Run a dump to completion; mode 0: CPU idle, 1: CPU busy every cycle, 2: CPU idle with stray dump_start pulses
    task automatic run_dump(input int mode, input int maxc, input string nm);
        bit finished;
        logic rd, wr;
        finished = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (mode == 1) begin
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc(1'b0, 1'b0, rd, wr, rnd64(), rnd64());
            end else if (mode == 2) begin
                cyc(1'b0, (i % 13) == 5, 1'b0, 1'b0, rnd64(), rnd64());
            end else begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd64(), rnd64());
            end
            if (dump_done) begin
                finished = 1'b1;
                break;
            end
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s_timeout actual=no_dump_done required=dump_done_within_%0d_cycles", nm, maxc);
        end
    endtask

    initial begin
        bit found;
        int pct;
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = rnd64();

        vt[0] = '{1'b0, 1'b1, 64'h10,  64'hAA,   1'b0, 1'b1, 6'd2,  64'hAA};
        vt[1] = '{1'b1, 1'b0, 64'h1F8, 64'h55,   1'b1, 1'b0, 6'd63, 64'h55};
        vt[2] = '{1'b1, 1'b1, 64'h28,  64'h1234, 1'b1, 1'b1, 6'd5,  64'h1234};
        vt[3] = '{1'b0, 1'b0, 64'h1F8, 64'hFFFF, 1'b0, 1'b0, 6'd0,  64'h0};
        vt[4] = '{1'b1, 1'b0, 64'h207, 64'h99,   1'b1, 1'b0, 6'd0,  64'h99};
        vt[5] = '{1'b0, 1'b1, 64'hF8,  64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 6'd31, 64'hDEADBEEF_CAFEF00D};

        // Reset state
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("rst_dump_busy",  64'(dump_busy),  64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_dump_done",  64'(dump_done),  64'd0);
        chk("rst_dump_addr",  64'(dump_addr),  64'd0);
        chk("rst_dump_data",  dump_data,       64'd0);

        // CPU pass-through table in IDLE
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd);
            chk("tbl_mem_memRead",   64'(mem_memRead),  64'(vt[i].e_rd));
            chk("tbl_mem_memWrite",  64'(mem_memWrite), 64'(vt[i].e_wr));
            chk("tbl_mem_address",   64'(mem_address),  64'(vt[i].e_a));
            chk("tbl_mem_writeData", mem_writeData,     vt[i].e_wd);
            chk("tbl_cpu_stall",     64'(cpu_stall),    64'd0);
            edge_chk();
        end

        // Full dump with CPU idle
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        run_dump(0, 200, "idle_dump");
        chk("idle_valid_count", 64'(cnt_valid),   64'd64);
        chk("idle_done_count",  64'(cnt_done),    64'd1);
        chk("idle_stall_count", 64'(cnt_stall),   64'd0);
        chk("idle_dump_cycles", 64'(cnt_dumpcyc), 64'd64);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Dump under continuous CPU traffic: forced slot every ninth cycle
        clr_counts();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h40, 64'd0);
        run_dump(1, 700, "starve_dump");
        chk("starve_valid_count", 64'(cnt_valid),   64'd64);
        chk("starve_done_count",  64'(cnt_done),    64'd1);
        chk("starve_stall_count", 64'(cnt_stall),   64'd64);
        chk("starve_dump_cycles", 64'(cnt_dumpcyc), 64'(64 * 9));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset mid-dump at word 20 aborts without dump_done, then restart from word 0
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
            if (dump_valid && dump_addr == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort_reach_word20 actual=not_seen required=dump_addr_20_within_100_cycles");
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("abort_busy",  64'(dump_busy),  64'd0);
        chk("abort_valid", 64'(dump_valid), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("abort_idle_busy", 64'(dump_busy), 64'd0);
        chk("abort_no_done",   64'(cnt_done),  64'd0);
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        run_dump(0, 200, "restart_dump");
        chk("restart_valid_count", 64'(cnt_valid), 64'd64);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset arriving exactly on a would-be forced slot must not stall the CPU
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd8, 64'd0);
        repeat (SMAX) cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd8, 64'd0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 64'd8, 64'd0);
        chk("reset_stall", 64'(cpu_stall), 64'd0);
        edge_chk();

        // Stray dump_start pulses during a dump are ignored
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        run_dump(2, 200, "restart_ignored");
        chk("ignore_valid_count", 64'(cnt_valid), 64'd64);
        chk("ignore_done_count",  64'(cnt_done),  64'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("done_start_ignored", 64'(dump_busy), 64'd0);

        // Randomized traffic with varying CPU load, occasional starts and resets
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 2 == 0) ? 95 : 40;
            for (int i = 0; i < 500; i++) begin
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 99) < pct, $urandom_range(0, 99) < (pct / 2),
                    rnd64(), rnd64());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: N, 64, data/address width; DEPTH, 64, dmem words dumped; STARVE_MAX, 8, max consecutive denied dump cycles.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have CPU ports: cpu_memRead in 1; cpu_memWrite in 1; cpu_addr in N (byte address); cpu_writeData in N; cpu_readData out N; cpu_stall out 1 (pipeline hold request).
REQ-004 SHALL have dump ports: dump_start in 1 (pulse); dump_busy out 1; dump_valid out 1; dump_addr out 6 (word index); dump_data out N; dump_done out 1 (pulse).
REQ-005 SHALL have memory ports: mem_memRead out 1; mem_memWrite out 1; mem_address out 6; mem_writeData out N; mem_readData in N (combinational read, same cycle).

Function
REQ-006 SHALL share one dmem between the CPU MEM stage and an internal dump sequencer that reads words 0..DEPTH-1 in order.
REQ-007 SHALL use FSM states IDLE, DUMP, DONE; IDLE->DUMP on dump_start; DUMP->DONE after word DEPTH-1 is granted; DONE->IDLE unconditionally after one cycle.
REQ-008 SHALL ignore dump_start while not in IDLE.
REQ-009 SHALL define cpu_req = cpu_memRead | cpu_memWrite; CPU grant drives mem_address = cpu_addr[8:3], mem_writeData = cpu_writeData, mem_memRead/mem_memWrite = cpu signals.
REQ-010 SHALL grant the CPU whenever cpu_req=1, except on a forced dump slot (REQ-012).
REQ-011 SHALL grant the dump sequencer in DUMP when cpu_req=0: mem_memRead=1, mem_memWrite=0, mem_address=word counter.
REQ-012 SHALL count consecutive DUMP cycles in which the dump is denied; when count = STARVE_MAX, the next cycle is a forced dump slot: dump granted, cpu_stall=1, mem_memWrite=0, count cleared.
REQ-013 SHALL keep cpu_stall=0 in every other cycle (combinational output, same cycle as forced slot).
REQ-014 SHALL drive cpu_readData = mem_readData combinationally at all times.
REQ-015 SHALL, on each dump grant, register mem_readData into dump_data and the word index into dump_addr, asserting dump_valid for exactly one cycle on the following cycle.
REQ-016 SHALL increment the 6-bit word counter after each dump grant; counter wraps to 0 on DUMP exit.
REQ-017 SHALL assert dump_busy in DUMP and DONE; dump_done=1 only in DONE, same cycle as dump_valid for word DEPTH-1.
REQ-018 SHALL, with no dump grant, drive memory outputs from the CPU (all zero when cpu_req=0).
REQ-019 SHALL never assert mem_memRead and mem_memWrite for the dump simultaneously; CPU read+write together are passed through unmodified.

Reset
REQ-020 SHALL, on reset=1 at a clk edge, enter IDLE, clear word counter and starvation counter, and drive dump_busy, dump_valid, dump_done = 0, dump_addr = 0, dump_data = 0.
REQ-021 SHALL abort an in-progress dump on reset with no dump_done pulse; reset takes priority over dump_start in the same cycle.
REQ-022 SHALL keep cpu_stall=0 while reset=1.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, DUMP, DONE) and the STARVE_MAX default in a shared package dmem_arb_pkg.
REQ-024 SHALL use the existing flopr register sub-module for the dump_data/dump_addr/dump_valid output stage; all other logic inline.

Verification
REQ-025 SHALL cover: dump_start with cpu_req=0 throughout -> dump_valid on 64 consecutive cycles, dump_addr 0..63, dump_done with word 63, cpu_stall never 1.
REQ-026 SHALL cover: cpu_memWrite=1, cpu_addr=0x10, data 0xAA during IDLE -> mem_address=2, mem_memWrite=1, mem_writeData=0xAA, cpu_stall=0.
REQ-027 SHALL cover: dump active with cpu_req=1 continuously -> forced slot every 9th cycle, cpu_stall=1 on that cycle only, dump completes after 64x9 cycles.
REQ-028 SHALL cover: reset asserted while dump_addr=20 -> next cycle IDLE, dump_busy=0, no dump_done; fresh dump_start restarts at word 0.
REQ-029 SHALL cover: dump_start pulsed during DUMP -> ignored, exactly 64 dump_valid pulses and one dump_done.
